preamble_inserter: RTL and testbench
====================================

# preamble_inserter

Transmit-side Schmidl-Cox framer. It prepends a synchronization preamble to each payload burst: a cyclic prefix followed by two identical half-symbols. This produces the repeated-half structure that the receive-side metric calculator and detector correlate against. Sits in TX user logic between the payload source and the RFNoC output stream, on the AXIS data clock.

## Interface
- HALF_FFT_SIZE, 2048: samples per preamble half-symbol (oversampled N/2); power of two.
- CP_SIZE, 512: cyclic-prefix samples; must satisfy 1 ≤ CP_SIZE ≤ HALF_FFT_SIZE.
- GUARD_LEN, 64: zero samples appended after payload (used only with the guard macro).

Ports:
- clk  in  1  AXIS data clock; everything single-clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous soft clear: return to IDLE, drop output register; RAM and frame_count kept.
- packet_length  in  16  payload samples per frame; latched at frame start.
- pre_wr_en  in  1  preamble RAM write strobe.
- pre_wr_addr  in  $clog2(HALF_FFT_SIZE)  preamble RAM write address.
- pre_wr_data  in  32  preamble sample, {I[31:16], Q[15:0]}.
- i_tdata  in  32  payload sample.
- i_tlast  in  1  ignored; framing is counted.
- i_tvalid  in  1  payload valid.
- i_tready  out  1  payload ready.
- o_tdata  out  32  framed output sample.
- o_tlast  out  1  last sample of frame.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- frame_start  out  1  one-cycle pulse when the first CP sample is accepted downstream.
- frame_count  out  16  frames completed; wraps at 0xFFFF→0.

## Operation
- Preamble RAM: HALF_FFT_SIZE×32, initialized to zero, not affected by reset or clear. Writes are accepted only in IDLE; writes in any other state are dropped.
- FSM states: IDLE → CP → HALF1 → HALF2 → PAYLOAD → (GUARD) → IDLE.
- IDLE: when i_tvalid=1, latch packet_length and enter CP. Do not consume the payload sample yet.
- CP: emit RAM[HALF_FFT_SIZE−CP_SIZE … HALF_FFT_SIZE−1].
- HALF1 and HALF2: each emits RAM[0 … HALF_FFT_SIZE−1].
- PAYLOAD: pass the latched-count of input samples through; i_tready=1 only in this state and only when the output register can load.
- If the latched length is 0, skip PAYLOAD; o_tlast is asserted on the last HALF2 sample (or on the last guard sample when guard is compiled in).
- o_tlast is asserted on the final sample of the frame. On that sample's acceptance: increment frame_count and return to IDLE.

## Timing
- Reset values: o_tvalid=0, o_tdata=0, o_tlast=0, i_tready=0, frame_start=0, frame_count=0, state=IDLE.
- Output is a single register stage, loaded when !o_tvalid || o_tready. While o_tvalid=1 and o_tready=0, o_tdata and o_tlast hold stable.
- RAM read is synchronous, 1 cycle. The read address must be prefetched so there are no bubbles.
- Latency: i_tvalid rising in IDLE → first CP sample on o_tvalid after exactly 2 cycles.
- Throughput: with o_tready=1 and i_tvalid=1 throughout, one sample per cycle with zero bubbles across CP/HALF1/HALF2/PAYLOAD/GUARD boundaries.
- Payload underflow (i_tvalid=0 in PAYLOAD): o_tvalid deasserts and the frame position is held; no fill samples are inserted.
- Next frame may start the cycle after the final-sample handshake. Back-to-back frames have a 1-cycle gap plus the 2-cycle latency.
- packet_length and RAM changes during a frame have no effect on that frame.
- Reset mid-frame: immediate abort. clear mid-frame: abort on the next edge. Either way the next frame restarts at CP sample 0.
- Counters sized to max(HALF_FFT_SIZE, 65536, GUARD_LEN). All arithmetic is unsigned; no saturation is needed.

## Configuration
- PREAMBLE_INSERTER_GUARD_EN defined: adds a GUARD state after PAYLOAD that emits GUARD_LEN samples of 0x00000000. o_tlast moves to the last guard sample. i_tready=0 during GUARD.
- Undefined: no GUARD state; GUARD_LEN is unused; o_tlast is on the last payload sample.

## Test plan
All scenarios use HALF_FFT_SIZE=8, CP_SIZE=4, RAM[k]=k+1.
- Basic frame: packet_length=5, payload 0x100–0x104, o_tready=1 → output 5,6,7,8, 1..8, 1..8, 0x100..0x104. Expect 25 consecutive valid cycles beginning 2 cycles after i_tvalid, o_tlast only on 0x104, frame_start once, frame_count=1.
- Random o_tready (50%) and random i_tvalid gaps, 3 frames → identical sample sequence per frame, outputs held under stall, no payload lost or duplicated, frame_count=3.
- packet_length=0, i_tvalid=1 → 20 preamble samples, o_tlast on the last 8, i_tready never asserted, the payload sample is still pending afterward.
- Write RAM[0]=0xDEAD during HALF1 → current frame shows 1 and the write is dropped; the next frame also shows 1. The same write in IDLE → next frame shows 0xDEAD.
- Assert reset_n=0 for 1 cycle at HALF2 sample 3 → o_tvalid=0 immediately, frame_count=0. The next frame restarts at CP value 5. Repeat with clear → frame_count preserved.
- With PREAMBLE_INSERTER_GUARD_EN and GUARD_LEN=3, packet_length=2 → payload followed by 0,0,0, o_tlast on the third zero, 25 samples total.

Source files
------------

// File: rtl/preamble_inserter.sv
// rtl/preamble_inserter.sv - Schmidl-Cox preamble framer: CP + two half-symbols ahead of each payload burst
// Optional guard tail after the payload is enabled by defining PREAMBLE_INSERTER_GUARD_EN.
module preamble_inserter #(
  parameter int HALF_FFT_SIZE = 2048,
  parameter int CP_SIZE       = 512,
  parameter int GUARD_LEN     = 64
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic [15:0]                      packet_length,
  input  logic                             pre_wr_en,
  input  logic [$clog2(HALF_FFT_SIZE)-1:0] pre_wr_addr,
  input  logic [31:0]                      pre_wr_data,
  input  logic [31:0]                      i_tdata,
  input  logic                             i_tlast,
  input  logic                             i_tvalid,
  output logic                             i_tready,
  output logic [31:0]                      o_tdata,
  output logic                             o_tlast,
  output logic                             o_tvalid,
  input  logic                             o_tready,
  output logic                             frame_start,
  output logic [15:0]                      frame_count
);

  localparam int AW      = $clog2(HALF_FFT_SIZE);
  localparam int CNT_A   = (HALF_FFT_SIZE > 65536) ? HALF_FFT_SIZE : 65536;
  localparam int CNT_MAX = (CNT_A > GUARD_LEN) ? CNT_A : GUARD_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CP, S_HALF1, S_HALF2, S_PAYLOAD, S_GUARD, S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [15:0]        len_q, len_d;

  logic [31:0]        ram [HALF_FFT_SIZE];
  logic [31:0]        ram_q;

  // Stage 1 holds the issued sample while its RAM read completes; stage 2 is the output register.
  logic               s1_valid, s1_ram, s1_last, s1_first;
  logic [31:0]        s1_data;
  logic               o_first;

  logic               adv;
  logic               issue, issue_ram, issue_last, issue_first, body_done;
  logic [AW-1:0]      issue_addr;
  logic [31:0]        issue_data;

  logic               unused_tlast;
  assign unused_tlast = i_tlast;

`ifndef PREAMBLE_INSERTER_GUARD_EN
  logic               unused_guard;
  assign unused_guard = (GUARD_LEN == 0);
`endif

  assign adv         = !o_tvalid || o_tready;
  assign i_tready    = (state_q == S_PAYLOAD) && adv;
  assign frame_start = o_tvalid && o_tready && o_first;
  assign cnt_inc     = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    issue       = 1'b0;
    issue_ram   = 1'b0;
    issue_last  = 1'b0;
    issue_first = 1'b0;
    issue_addr  = '0;
    issue_data  = '0;
    body_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_tvalid) begin
          state_d = S_CP;
          cnt_d   = '0;
          len_d   = packet_length;
        end
      end
      S_CP: begin
        if (adv) begin
          issue       = 1'b1;
          issue_ram   = 1'b1;
          issue_first = (cnt_q == '0);
          issue_addr  = AW'(HALF_FFT_SIZE - CP_SIZE) + cnt_q[AW-1:0];
          if (cnt_q == CNT_W'(CP_SIZE - 1)) begin
            state_d = S_HALF1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_HALF1, S_HALF2: begin
        if (adv) begin
          issue      = 1'b1;
          issue_ram  = 1'b1;
          issue_addr = cnt_q[AW-1:0];
          if (cnt_q == CNT_W'(HALF_FFT_SIZE - 1)) begin
            cnt_d = '0;
            if (state_q == S_HALF1)
              state_d = S_HALF2;
            else if (len_q == 16'd0)
              body_done = 1'b1;
            else
              state_d = S_PAYLOAD;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_PAYLOAD: begin
        if (adv && i_tvalid) begin
          issue      = 1'b1;
          issue_data = i_tdata;
          if (cnt_inc == CNT_W'(len_q)) begin
            cnt_d     = '0;
            body_done = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
`ifdef PREAMBLE_INSERTER_GUARD_EN
      S_GUARD: begin
        if (adv) begin
          issue = 1'b1;
          if (cnt_q == CNT_W'(GUARD_LEN - 1)) begin
            cnt_d      = '0;
            issue_last = 1'b1;
            state_d    = S_DRAIN;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
`endif
      S_DRAIN: begin
        // Hold off the next frame until the final sample has left the output register.
        if (o_tvalid && o_tready && o_tlast)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (body_done) begin
`ifdef PREAMBLE_INSERTER_GUARD_EN
      state_d = S_GUARD;
`else
      issue_last = 1'b1;
      state_d    = S_DRAIN;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (pre_wr_en && state_q == S_IDLE)
      ram[pre_wr_addr] <= pre_wr_data;
    if (issue && issue_ram)
      ram_q <= ram[issue_addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      s1_valid    <= 1'b0;
      s1_ram      <= 1'b0;
      s1_last     <= 1'b0;
      s1_first    <= 1'b0;
      s1_data     <= '0;
      o_tvalid    <= 1'b0;
      o_tdata     <= '0;
      o_tlast     <= 1'b0;
      o_first     <= 1'b0;
      frame_count <= '0;
    end else if (clear) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_first <= 1'b0;
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
      o_first  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      if (o_tvalid && o_tready && o_tlast)
        frame_count <= frame_count + 16'd1;
      if (adv) begin
        o_tvalid <= s1_valid;
        if (s1_valid) begin
          o_tdata <= s1_ram ? ram_q : s1_data;
          o_tlast <= s1_last;
          o_first <= s1_first;
        end else begin
          o_tlast <= 1'b0;
          o_first <= 1'b0;
        end
        s1_valid <= issue;
        if (issue) begin
          s1_ram   <= issue_ram;
          s1_data  <= issue_data;
          s1_last  <= issue_last;
          s1_first <= issue_first;
        end
      end
    end
  end

endmodule

// File: tb/tb_preamble_inserter.sv
// tb/tb_preamble_inserter.sv - scoreboard bench for preamble_inserter (HALF=8, CP=4, RAM[k]=k+1)
module tb_preamble_inserter;

  localparam int HALF = 8;
  localparam int CP   = 4;
`ifdef PREAMBLE_INSERTER_GUARD_EN
  localparam int GL = 3;
`else
  localparam int GL = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] packet_length = 16'd0;
  logic        pre_wr_en = 1'b0;
  logic [2:0]  pre_wr_addr = 3'd0;
  logic [31:0] pre_wr_data = 32'd0;
  logic [31:0] i_tdata = 32'd0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic        frame_start;
  logic [15:0] frame_count;

  preamble_inserter #(.HALF_FFT_SIZE(HALF), .CP_SIZE(CP), .GUARD_LEN(3)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .packet_length(packet_length),
    .pre_wr_en(pre_wr_en), .pre_wr_addr(pre_wr_addr), .pre_wr_data(pre_wr_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc, first_cyc, last_cyc;
  int          acc_count, fs_count, rdy_count;
  bit          mon_en = 1'b1;
  bit          rand_ready = 1'b0;
  bit          hold_pend = 1'b0;
  logic [32:0] held_v, exp_v;
  logic [32:0] sb[$];
  logic [31:0] ram_model[HALF];

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    o_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: scoreboard pops on every accepted sample, plus stall stability.
  always @(negedge clk) begin
    if (mon_en && hold_pend) begin
      checks++;
      if (!o_tvalid || {o_tlast, o_tdata} !== held_v) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b %h required %h", o_tvalid, {o_tlast, o_tdata}, held_v);
      end
    end
    hold_pend = mon_en && o_tvalid && !o_tready;
    held_v    = {o_tlast, o_tdata};
    if (mon_en && o_tvalid && o_tready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: got %h required none", {o_tlast, o_tdata});
      end else begin
        exp_v = sb.pop_front();
        if ({o_tlast, o_tdata} !== exp_v) begin
          errors++;
          $display("FAIL sample: got last=%b data=%h required last=%b data=%h",
                   o_tlast, o_tdata, exp_v[32], exp_v[31:0]);
        end
      end
      if (acc_count == 0) first_cyc = cyc;
      last_cyc = cyc;
      acc_count++;
    end
    if (frame_start) fs_count++;
    if (i_tready) rdy_count++;
  end

  task automatic push_expected(input int len, input logic [31:0] base);
    logic [31:0] vals[$];
    for (int k = HALF - CP; k < HALF; k++) vals.push_back(ram_model[k]);
    for (int h = 0; h < 2; h++)
      for (int k = 0; k < HALF; k++) vals.push_back(ram_model[k]);
    for (int i = 0; i < len; i++) vals.push_back(base + 32'(i));
    for (int g = 0; g < GL; g++) vals.push_back(32'd0);
    for (int i = 0; i < vals.size(); i++) sb.push_back({(i == vals.size() - 1), vals[i]});
  endtask

  task automatic write_ram(input int addr, input logic [31:0] data);
    @(posedge clk); #1;
    pre_wr_en = 1'b1; pre_wr_addr = 3'(addr); pre_wr_data = data;
    @(posedge clk); #1;
    pre_wr_en = 1'b0;
  endtask

  task automatic run_frame(input int len, input logic [31:0] base, input bit hold, input bit rnd);
    int          idx = 0;
    bit          done = 1'b0;
    logic [15:0] fc0;
    fc0 = frame_count;
    push_expected(len, base);
    packet_length = 16'(len);
    acc_count = 0; fs_count = 0; rdy_count = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk); #1;
      if (idx < len || hold) begin
        i_tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        i_tdata  = base + 32'(idx);
      end else begin
        i_tvalid = 1'b0;
      end
      if (c == 0) start_cyc = cyc + 1;
      @(negedge clk);
      if (i_tvalid && i_tready) idx++;
      if (frame_count != fc0) begin
        done = 1'b1;
        i_tvalid = 1'b0;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL frame_timeout: got frame_count=%0d required %0d", frame_count, fc0 + 16'd1);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (o_tvalid !== 1'b0)     begin errors++; $display("FAIL rst_o_tvalid: got %b required 0", o_tvalid); end
    if (o_tdata !== 32'd0)     begin errors++; $display("FAIL rst_o_tdata: got %h required 0", o_tdata); end
    if (o_tlast !== 1'b0)      begin errors++; $display("FAIL rst_o_tlast: got %b required 0", o_tlast); end
    if (i_tready !== 1'b0)     begin errors++; $display("FAIL rst_i_tready: got %b required 0", i_tready); end
    if (frame_start !== 1'b0)  begin errors++; $display("FAIL rst_frame_start: got %b required 0", frame_start); end
    if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_frame_count: got %0d required 0", frame_count); end
    reset_n = 1'b1;
    for (int k = 0; k < HALF; k++) begin
      ram_model[k] = 32'(k + 1);
      write_ram(k, ram_model[k]);
    end
  endtask

  task automatic test_basic;
    run_frame(5, 32'h100, 1'b0, 1'b0);
    checks += 5;
    if (acc_count != 25 + GL) begin errors++; $display("FAIL basic_count: got %0d required %0d", acc_count, 25 + GL); end
    if (first_cyc - start_cyc != 2) begin errors++; $display("FAIL basic_latency: got %0d required 2", first_cyc - start_cyc); end
    if (last_cyc - first_cyc != 24 + GL) begin errors++; $display("FAIL basic_bubbles: got span %0d required %0d", last_cyc - first_cyc, 24 + GL); end
    if (fs_count != 1) begin errors++; $display("FAIL basic_frame_start: got %0d required 1", fs_count); end
    if (frame_count !== 16'd1) begin errors++; $display("FAIL basic_frame_count: got %0d required 1", frame_count); end
  endtask

  task automatic test_random;
    logic [15:0] fc0;
    int lens[3] = '{3, 7, 1};
    fc0 = frame_count;
    rand_ready = 1'b1;
    for (int f = 0; f < 3; f++) run_frame(lens[f], 32'h1000 * (f + 1), 1'b0, 1'b1);
    rand_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (frame_count !== fc0 + 16'd3) begin errors++; $display("FAIL random_frame_count: got %0d required %0d", frame_count, fc0 + 16'd3); end
  endtask

  task automatic test_zero_len;
    run_frame(0, 32'h400, 1'b1, 1'b0);
    checks += 2;
    if (acc_count != 20 + GL) begin errors++; $display("FAIL zero_count: got %0d required %0d", acc_count, 20 + GL); end
    if (rdy_count != 0) begin errors++; $display("FAIL zero_i_tready: got %0d cycles required 0", rdy_count); end
  endtask

  task automatic test_ram_write;
    fork
      run_frame(2, 32'h200, 1'b0, 1'b0);
      begin
        repeat (3) @(negedge clk);
        for (int c = 0; c < 100 && acc_count < 5; c++) @(negedge clk);
        @(posedge clk); #1;
        pre_wr_en = 1'b1; pre_wr_addr = 3'd0; pre_wr_data = 32'hDEAD;
        @(posedge clk); #1;
        pre_wr_en = 1'b0;
      end
    join
    run_frame(2, 32'h210, 1'b0, 1'b0);
    ram_model[0] = 32'hDEAD;
    write_ram(0, 32'hDEAD);
    run_frame(2, 32'h220, 1'b0, 1'b0);
    ram_model[0] = 32'd1;
    write_ram(0, 32'd1);
  endtask

  task automatic test_abort(input bit use_clear);
    logic [15:0] fc_before;
    fc_before = frame_count;
    packet_length = 16'd2;
    acc_count = 0;
    push_expected(2, 32'h300);
    @(posedge clk); #1;
    i_tvalid = 1'b1; i_tdata = 32'h300;
    for (int c = 0; c < 200 && acc_count < 15; c++) @(negedge clk);
    mon_en = 1'b0;
    i_tvalid = 1'b0;
    checks++;
    if (acc_count < 15) begin errors++; $display("FAIL abort_reach_half2: got %0d samples required 15", acc_count); end
    if (use_clear) begin
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      checks += 2;
      if (o_tvalid !== 1'b0) begin errors++; $display("FAIL clear_o_tvalid: got %b required 0", o_tvalid); end
      if (frame_count !== fc_before) begin errors++; $display("FAIL clear_frame_count: got %0d required %0d", frame_count, fc_before); end
    end else begin
      reset_n = 1'b0;
      #1;
      checks += 2;
      if (o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_o_tvalid: got %b required 0", o_tvalid); end
      if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count: got %0d required 0", frame_count); end
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
    end
    sb.delete();
    hold_pend = 1'b0;
    mon_en = 1'b1;
    run_frame(1, 32'h310, 1'b0, 1'b0);
    checks++;
    if (frame_count !== (use_clear ? fc_before + 16'd1 : 16'd1)) begin
      errors++;
      $display("FAIL abort_restart_count: got %0d required %0d", frame_count, use_clear ? fc_before + 16'd1 : 16'd1);
    end
  endtask

`ifdef PREAMBLE_INSERTER_GUARD_EN
  task automatic test_guard;
    run_frame(2, 32'h500, 1'b0, 1'b0);
    checks++;
    if (acc_count != 25) begin errors++; $display("FAIL guard_count: got %0d required 25", acc_count); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_random;
    test_zero_len;
    test_ram_write;
    test_abort(1'b0);
    test_abort(1'b1);
`ifdef PREAMBLE_INSERTER_GUARD_EN
    test_guard;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
